systolic_input_feeder: RTL and testbench

SYSTOLIC_INPUT_FEEDER -- requirements
Module: systolic_input_feeder

---
 rtl/systolic_input_feeder.sv | 171 +++++++++++++++++
 tb/tb_systolic_input_feeder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_input_feeder.sv
`default_nettype none
// ============================================================================
// systolic_input_feeder : streams matrix rows from the operand buffer to the
// skew stage, then LANES-1 zero words. Optional macro FEEDER_STALL_CNT_EN.
// Rev 1.0
// ============================================================================
module systolic_input_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 10,
  parameter int ADDR_WIDTH = 10,
  parameter int ROW_WIDTH  = 10
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic [ADDR_WIDTH-1:0]       base_addr_i,
  input  logic [ROW_WIDTH-1:0]        num_rows_i,
  input  logic                        stall_i,
  output logic                        sram_en_o,
  output logic [ADDR_WIDTH-1:0]       sram_addr_o,
  input  logic [DATA_WIDTH*LANES-1:0] sram_rdata_i,
  output logic [DATA_WIDTH*LANES-1:0] word_o,
  output logic                        en_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [15:0]                 stall_cnt_o
);

  localparam int WORD_W  = DATA_WIDTH * LANES;
  localparam int FLUSH_W = (LANES > 2) ? $clog2(LANES) : 1;
  localparam logic [FLUSH_W-1:0] C_FLUSH_LAST = FLUSH_W'(LANES - 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ROW_WIDTH-1:0]  r_rows;
  logic [ROW_WIDTH-1:0]  r_issued;
  logic [ROW_WIDTH-1:0]  r_presented;
  logic [FLUSH_W-1:0]    r_flush_cnt;
  logic                  r_rd_pending;
  logic                  r_hold_valid;
  logic [WORD_W-1:0]     r_hold_data;

  logic w_accept;
  logic w_issue;
  logic w_present_hold;
  logic w_present_rd;
  logic w_capture;
  logic w_flush_en;

  always_comb begin
    w_state_nxt    = r_state;
    w_accept       = 1'b0;
    w_issue        = 1'b0;
    w_present_hold = 1'b0;
    w_present_rd   = 1'b0;
    w_capture      = 1'b0;
    w_flush_en     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          if (num_rows_i != '0) begin
            w_accept    = 1'b1;
            w_state_nxt = STREAM;
          end else begin
            w_state_nxt = DONE;
          end
        end
      end
      STREAM: begin
        // A full hold register drains in any unstalled cycle, so a new read
        // may be issued alongside it; its data can never collide with the hold.
        w_issue        = !stall_i && (r_issued != r_rows);
        w_present_hold = r_hold_valid && !stall_i;
        w_present_rd   = r_rd_pending && !r_hold_valid && !stall_i;
        w_capture      = r_rd_pending && !r_hold_valid && stall_i;
        // Leave on the registered presented count: one idle cycle precedes FLUSH.
        if (r_presented == r_rows) begin
          w_state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        w_flush_en = !stall_i;
        if (w_flush_en && (r_flush_cnt == C_FLUSH_LAST)) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_rows       <= '0;
      r_issued     <= '0;
      r_presented  <= '0;
      r_flush_cnt  <= '0;
      r_rd_pending <= 1'b0;
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_rd_pending <= w_issue;
      if (w_accept) begin
        r_addr      <= base_addr_i;
        r_rows      <= num_rows_i;
        r_issued    <= '0;
        r_presented <= '0;
        r_flush_cnt <= '0;
      end else begin
        if (w_issue) begin
          r_addr   <= r_addr + ADDR_WIDTH'(1);
          r_issued <= r_issued + ROW_WIDTH'(1);
        end
        if (w_present_hold || w_present_rd) begin
          r_presented <= r_presented + ROW_WIDTH'(1);
        end
        if (w_flush_en) begin
          r_flush_cnt <= r_flush_cnt + FLUSH_W'(1);
        end
      end
      if (w_capture) begin
        r_hold_valid <= 1'b1;
        r_hold_data  <= sram_rdata_i;
      end else if (w_present_hold) begin
        r_hold_valid <= 1'b0;
      end
    end
  end

  assign sram_en_o   = w_issue;
  assign sram_addr_o = w_issue ? r_addr : '0;
  assign en_o        = w_present_hold || w_present_rd || w_flush_en;
  assign word_o      = w_present_hold ? r_hold_data :
                       w_present_rd   ? sram_rdata_i : '0;
  assign busy_o      = (r_state == STREAM) || (r_state == FLUSH) || (w_accept && rst_ni);
  assign done_o      = (r_state == DONE);

`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
    end else if (w_accept) begin
      r_stall_cnt <= '0;
    end else if (busy_o && stall_i && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_systolic_input_feeder.sv
`default_nettype none
// Bench for systolic_input_feeder: job table against a word/address scoreboard,
// plus zero-row, mid-job reset and start-in-DONE sequences.
module tb_systolic_input_feeder;
  localparam int DW = 8;
  localparam int LN = 10;
  localparam int AW = 10;
  localparam int RW = 10;
  localparam int WW = DW * LN;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic          stall_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [RW-1:0] num_rows_i = '0;
  logic          sram_en_o;
  logic [AW-1:0] sram_addr_o;
  logic [WW-1:0] sram_rdata_i = '0;
  logic [WW-1:0] word_o;
  logic          en_o;
  logic          busy_o;
  logic          done_o;
  logic [15:0]   stall_cnt_o;

  int total = 0;
  int bad   = 0;

  logic [WW-1:0] exp_q[$];
  logic [AW-1:0] addr_q[$];

  typedef struct {
    logic [AW-1:0] base;
    logic [RW-1:0] rows;
    int            stall_start;
    int            stall_len;
    int            exp_done;
    bit            restart_in_done;
  } vec_t;

  vec_t vecs[6];

  always #5 clk_i = ~clk_i;

  systolic_input_feeder #(
    .DATA_WIDTH(DW), .LANES(LN), .ADDR_WIDTH(AW), .ROW_WIDTH(RW)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .num_rows_i  (num_rows_i),
    .stall_i     (stall_i),
    .sram_en_o   (sram_en_o),
    .sram_addr_o (sram_addr_o),
    .sram_rdata_i(sram_rdata_i),
    .word_o      (word_o),
    .en_o        (en_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .stall_cnt_o (stall_cnt_o)
  );

  function automatic logic [WW-1:0] mem_word(input logic [AW-1:0] a);
    logic [WW-1:0] w;
    w = '0;
    for (int l = 0; l < LN; l++) w[l*DW +: DW] = DW'(int'(a) * 3 + l * 37 + 1);
    return w;
  endfunction

  // Buffer model: one-cycle read latency, non-zero junk when not reading.
  always @(posedge clk_i) begin
    sram_rdata_i <= sram_en_o ? mem_word(sram_addr_o) : {LN{8'hA5}};
  end

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (en_o) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_en: got word %h expected no word", word_o);
        end else begin
          check("word", word_o, exp_q.pop_front());
        end
      end else begin
        check("word_idle_zero", word_o, '0);
      end
      if (sram_en_o) begin
        if (addr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_read: got addr %h expected no read", sram_addr_o);
        end else begin
          check("read_addr", WW'(sram_addr_o), WW'(addr_q.pop_front()));
        end
      end
    end
  end

  function automatic int exp_stall_cnt(input int n);
`ifdef FEEDER_STALL_CNT_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  // Called and returns at posedge+1.
  task automatic run_job(input vec_t v);
    int cyc;
    int done_at;
    for (int i = 0; i < int'(v.rows); i++) begin
      addr_q.push_back(v.base + AW'(i));
      exp_q.push_back(mem_word(v.base + AW'(i)));
    end
    for (int i = 0; i < LN - 1; i++) exp_q.push_back('0);
    start_i     = 1'b1;
    base_addr_i = v.base;
    num_rows_i  = v.rows;
    stall_i     = (v.stall_len > 0) && (v.stall_start == 0);
    cyc = 0;
    done_at = -1;
    while (done_at < 0 && cyc < 200) begin
      @(negedge clk_i);
      if (cyc == 0) check("busy_at_start", WW'(busy_o), WW'(1));
      if (done_o) begin
        done_at = cyc;
        check("busy_at_done", WW'(busy_o), WW'(0));
      end else if (cyc == v.exp_done - 1) begin
        check("busy_before_done", WW'(busy_o), WW'(1));
      end
      @(posedge clk_i); #1;
      cyc++;
      start_i = v.restart_in_done && (cyc == v.exp_done);
      stall_i = (cyc >= v.stall_start) && (cyc < v.stall_start + v.stall_len);
    end
    check("done_cycle", WW'(done_at), WW'(v.exp_done));
    start_i = 1'b0;
    stall_i = 1'b0;
    @(negedge clk_i);
    check("busy_after_done", WW'(busy_o), WW'(0));
    check("sb_words_left", WW'(exp_q.size()), WW'(0));
    check("sb_reads_left", WW'(addr_q.size()), WW'(0));
    check("stall_cnt", WW'(stall_cnt_o), WW'(exp_stall_cnt(v.stall_len)));
    exp_q.delete();
    addr_q.delete();
    @(posedge clk_i); #1;
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_sram_en"}, WW'(sram_en_o), WW'(0));
    check({name, "_sram_addr"}, WW'(sram_addr_o), WW'(0));
    check({name, "_word"}, word_o, '0);
    check({name, "_en"}, WW'(en_o), WW'(0));
    check({name, "_busy"}, WW'(busy_o), WW'(0));
    check({name, "_done"}, WW'(done_o), WW'(0));
    check({name, "_stall_cnt"}, WW'(stall_cnt_o), WW'(0));
  endtask

  initial begin
    bit saw_done;
    //          base     rows  st  len done restart
    vecs[0] = '{10'h010, 10'd3, 0, 0, 15, 1'b0};
    vecs[1] = '{10'h3FE, 10'd4, 0, 0, 16, 1'b1};
    vecs[2] = '{10'h100, 10'd4, 3, 3, 19, 1'b0};
    vecs[3] = '{10'h020, 10'd1, 0, 0, 13, 1'b0};
    vecs[4] = '{10'h050, 10'd6, 4, 5, 23, 1'b0};
    vecs[5] = '{10'h0C0, 10'd2, 6, 2, 16, 1'b0};

    // Reset state, including a start request held during reset.
    start_i = 1'b1; num_rows_i = 10'd5; stall_i = 1'b1;
    #1;
    check_outputs_zero("in_reset");
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    start_i = 1'b0; stall_i = 1'b0; num_rows_i = '0;
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_outputs_zero("after_reset");
    @(posedge clk_i); #1;

    for (int i = 0; i < 6; i++) run_job(vecs[i]);

    // Zero-row job: done next cycle, never busy, no reads.
    start_i = 1'b1; num_rows_i = '0; base_addr_i = 10'h030;
    @(negedge clk_i);
    check("zero_busy_c0", WW'(busy_o), WW'(0));
    check("zero_done_c0", WW'(done_o), WW'(0));
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(negedge clk_i);
    check("zero_done_c1", WW'(done_o), WW'(1));
    check("zero_busy_c1", WW'(busy_o), WW'(0));
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("zero_done_c2", WW'(done_o), WW'(0));
    @(posedge clk_i); #1;

    // Mid-job reset on the second data cycle.
    for (int i = 0; i < 4; i++) begin
      addr_q.push_back(10'h200 + AW'(i));
      exp_q.push_back(mem_word(10'h200 + AW'(i)));
    end
    start_i = 1'b1; num_rows_i = 10'd4; base_addr_i = 10'h200;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    exp_q.delete();
    addr_q.delete();
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      if (done_o) saw_done = 1'b1;
    end
    check("no_done_after_abort", WW'(saw_done), WW'(0));
    @(posedge clk_i); #1;
    run_job(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
